// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a ROWS x COLS key matrix by driving one column at a
// time, synchronises the row lines, resolves one candidate key per full scan
// frame, debounces across frames and queues press events in a small FIFO.
// Build option: define KEYPAD_RELEASE_EVT_EN to also queue release events
// (adds the key_release output and one bit per FIFO entry).
module keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 16,
  parameter int DEBOUNCE   = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int KEY_W     = $clog2(ROWS * COLS),
  localparam int CW        = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  rows,
  output logic [COLS-1:0]  cols,
  output logic [CW-1:0]    col_idx,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             held,
  output logic [KEY_W-1:0] held_code,
  output logic             multi,
  output logic             overflow,
`ifdef KEYPAD_RELEASE_EVT_EN
  output logic             key_release,
`endif
  input  logic             clr_overflow
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;
`ifdef KEYPAD_RELEASE_EVT_EN
  localparam int FW = KEY_W + 1;
`else
  localparam int FW = KEY_W;
`endif

  // scan sequencing
  logic [ROWS-1:0]  r_rows_meta;
  logic [ROWS-1:0]  r_rows_sync;
  logic [DW-1:0]    r_dwell;
  logic [CW-1:0]    r_col_idx;
  logic [COLS-1:0]  r_cols;
  logic             w_scan_tick;
  logic             w_last_col;
  logic             w_frame_end;

  // per-column capture and frame accumulation
  logic             w_col_found;
  logic [KEY_W-1:0] w_col_code;
  logic [3:0]       w_col_hits;
  logic             r_acc_found;
  logic [KEY_W-1:0] r_acc_code;
  logic [1:0]       r_acc_hits;
  logic             w_take_col;
  logic             w_frm_found;
  logic [KEY_W-1:0] w_frm_code;
  logic [3:0]       w_hits_sum;
  logic             w_frm_multi;
  logic [1:0]       w_frm_hits;

  // debounce
  logic             r_prev_found;
  logic [KEY_W-1:0] r_prev_code;
  logic [3:0]       r_stable;
  logic             w_same;
  logic [3:0]       w_stable_next;
  logic             w_differs;
  logic             w_accept;
  logic             r_held;
  logic [KEY_W-1:0] r_held_code;
  logic             r_multi;

  // events and FIFO
  logic             w_push_req;
  logic [FW-1:0]    w_push_data;
  logic [FW-1:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [NW-1:0]    r_count;
  logic             r_key_valid;
  logic [FW-1:0]    r_key_head;
  logic             w_full;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_drop;
  logic [PW-1:0]    w_rd_ptr_next;
  logic [NW-1:0]    w_count_next;
  logic [FW-1:0]    w_head_next;
  logic             r_overflow;

`ifdef KEYPAD_RELEASE_EVT_EN
  logic             r_pend_valid;
  logic [KEY_W-1:0] r_pend_code;
  logic             w_pend_set;
`endif

  assign w_scan_tick = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_last_col  = (r_col_idx == CW'(COLS - 1));
  assign w_frame_end = w_scan_tick && w_last_col;

  // Two-flop row synchroniser plus the dwell counter and column rotation
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows_meta <= {ROWS{1'b0}};
      r_rows_sync <= {ROWS{1'b0}};
      r_dwell     <= {DW{1'b0}};
      r_col_idx   <= {CW{1'b0}};
      r_cols      <= COLS'(1'b1);
    end else begin
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
      if (w_scan_tick) begin
        r_dwell   <= {DW{1'b0}};
        r_col_idx <= w_last_col ? {CW{1'b0}} : (r_col_idx + CW'(1'b1));
        r_cols    <= {r_cols[COLS-2:0], r_cols[COLS-1]};
      end else begin
        r_dwell   <= r_dwell + DW'(1'b1);
      end
    end
  end

  // Lowest pressed row in the driven column and the number of rows seen
  always_comb begin
    w_col_found = 1'b0;
    w_col_code  = {KEY_W{1'b0}};
    w_col_hits  = 4'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      w_col_found = w_col_found | r_rows_sync[i];
      w_col_code  = r_rows_sync[i] ? (KEY_W'(i * COLS) + KEY_W'(r_col_idx)) : w_col_code;
      w_col_hits  = w_col_hits + {3'b000, r_rows_sync[i]};
    end
  end

  // Merge this column into the frame result and evaluate the debounce rule
  always_comb begin
    w_take_col    = w_col_found && (!r_acc_found || (w_col_code < r_acc_code));
    w_frm_found   = r_acc_found || w_col_found;
    w_frm_code    = w_take_col ? w_col_code : r_acc_code;
    w_hits_sum    = {2'b00, r_acc_hits} + w_col_hits;
    w_frm_multi   = (w_hits_sum >= 4'd2);
    w_frm_hits    = w_frm_multi ? 2'd2 : w_hits_sum[1:0];
    w_same        = (w_frm_found == r_prev_found) &&
                    (!w_frm_found || (w_frm_code == r_prev_code));
    w_stable_next = w_same ? ((r_stable == 4'd15) ? 4'd15 : (r_stable + 4'd1)) : 4'd1;
    w_differs     = (w_frm_found != r_held) || (w_frm_found && (w_frm_code != r_held_code));
    w_accept      = w_frame_end && (w_stable_next >= 4'(DEBOUNCE)) && w_differs;
  end

  // Frame accumulators, previous-frame candidate, stable count and debounced key
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_found  <= 1'b0;
      r_acc_code   <= {KEY_W{1'b0}};
      r_acc_hits   <= 2'd0;
      r_prev_found <= 1'b0;
      r_prev_code  <= {KEY_W{1'b0}};
      r_stable     <= 4'd0;
      r_multi      <= 1'b0;
      r_held       <= 1'b0;
      r_held_code  <= {KEY_W{1'b0}};
    end else begin
      if (w_frame_end) begin
        r_acc_found  <= 1'b0;
        r_acc_code   <= {KEY_W{1'b0}};
        r_acc_hits   <= 2'd0;
        r_prev_found <= w_frm_found;
        r_prev_code  <= w_frm_code;
        r_stable     <= w_stable_next;
        r_multi      <= w_frm_multi;
      end else if (w_scan_tick) begin
        r_acc_found  <= w_frm_found;
        r_acc_code   <= w_frm_code;
        r_acc_hits   <= w_frm_hits;
      end
      if (w_accept) begin
        r_held      <= w_frm_found;
        r_held_code <= w_frm_found ? w_frm_code : {KEY_W{1'b0}};
      end
    end
  end

`ifdef KEYPAD_RELEASE_EVT_EN
  // Key change: release of the old key now, press of the new key one cycle later
  always_comb begin
    w_push_req  = 1'b0;
    w_push_data = {FW{1'b0}};
    w_pend_set  = 1'b0;
    if (r_pend_valid) begin
      w_push_req  = 1'b1;
      w_push_data = {1'b0, r_pend_code};
    end else if (w_accept && r_held) begin
      w_push_req  = 1'b1;
      w_push_data = {1'b1, r_held_code};
      w_pend_set  = w_frm_found;
    end else if (w_accept) begin
      w_push_req  = w_frm_found;
      w_push_data = {1'b0, w_frm_code};
    end else begin
      w_push_req  = 1'b0;
    end
  end

  // Holds the press that follows a release by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend_valid <= 1'b0;
      r_pend_code  <= {KEY_W{1'b0}};
    end else begin
      r_pend_valid <= w_pend_set;
      if (w_pend_set) begin
        r_pend_code <= w_frm_code;
      end
    end
  end
`else
  // A newly accepted key is queued as a press; going back to no key queues nothing
  always_comb begin
    w_push_req  = w_accept && w_frm_found;
    w_push_data = w_frm_code;
  end
`endif

  // FIFO push/pop qualification, drop detection and next head value
  always_comb begin
    w_full        = (r_count == NW'(FIFO_DEPTH));
    w_pop         = r_key_valid && key_ready;
    w_push_ok     = w_push_req && (!w_full || w_pop);
    w_drop        = w_push_req && w_full && !w_pop;
    w_rd_ptr_next = w_pop ? (r_rd_ptr + PW'(1'b1)) : r_rd_ptr;
    w_count_next  = r_count + NW'(w_push_ok) - NW'(w_pop);
    if (w_count_next == {NW{1'b0}}) begin
      w_head_next = {FW{1'b0}};
    end else if (w_push_ok && (r_wr_ptr == w_rd_ptr_next)) begin
      w_head_next = w_push_data;
    end else begin
      w_head_next = r_mem[w_rd_ptr_next];
    end
  end

  // FIFO pointers, occupancy and the registered head view
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= {PW{1'b0}};
      r_rd_ptr    <= {PW{1'b0}};
      r_count     <= {NW{1'b0}};
      r_key_valid <= 1'b0;
      r_key_head  <= {FW{1'b0}};
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1'b1);
      end
      r_rd_ptr    <= w_rd_ptr_next;
      r_count     <= w_count_next;
      r_key_valid <= (w_count_next != {NW{1'b0}});
      r_key_head  <= w_head_next;
    end
  end

  // FIFO storage; contents are don't-care while the occupancy is zero
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) begin
      r_mem[r_wr_ptr] <= w_push_data;
    end
  end

  // Sticky overflow; a drop in the same cycle wins over the clear request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  assign cols      = r_cols;
  assign col_idx   = r_col_idx;
  assign key_code  = r_key_head[KEY_W-1:0];
  assign key_valid = r_key_valid;
  assign held      = r_held;
  assign held_code = r_held_code;
  assign multi     = r_multi;
  assign overflow  = r_overflow;
`ifdef KEYPAD_RELEASE_EVT_EN
  assign key_release = r_key_head[KEY_W];
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a 4x4 instance driven by key-set segments, plus a
// 3x5 instance with one fixed key.
module tb_keypad_scanner;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int NKEY  = 16;
  localparam int FRAME = 64;
  localparam int DEPTH = 4;
  localparam int DEB   = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic [1:0]      col_idx;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_ready = 1'b0;
  logic            held;
  logic [3:0]      held_code;
  logic            multi;
  logic            overflow;
  logic            clr_overflow = 1'b0;
  logic [NKEY-1:0] press_mask = '0;
`ifdef KEYPAD_RELEASE_EVT_EN
  logic            key_release;
`endif

  // second instance: 3 rows x 5 columns
  logic [2:0]  s_rows;
  logic [4:0]  s_cols;
  logic [2:0]  s_col_idx;
  logic [3:0]  s_key_code;
  logic        s_key_valid;
  logic        s_key_ready = 1'b0;
  logic        s_held;
  logic [3:0]  s_held_code;
  logic        s_multi;
  logic        s_overflow;
  logic        s_clr = 1'b0;
  logic [14:0] s_press_mask = 15'h4000;   // row 2, col 4 -> code 14
`ifdef KEYPAD_RELEASE_EVT_EN
  logic        s_key_release;
`endif

  keypad_scanner dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols), .col_idx(col_idx),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .held(held), .held_code(held_code), .multi(multi), .overflow(overflow),
`ifdef KEYPAD_RELEASE_EVT_EN
    .key_release(key_release),
`endif
    .clr_overflow(clr_overflow)
  );

  keypad_scanner #(.ROWS(3), .COLS(5)) dut_s (
    .clk(clk), .reset(reset), .rows(s_rows), .cols(s_cols), .col_idx(s_col_idx),
    .key_code(s_key_code), .key_valid(s_key_valid), .key_ready(s_key_ready),
    .held(s_held), .held_code(s_held_code), .multi(s_multi), .overflow(s_overflow),
`ifdef KEYPAD_RELEASE_EVT_EN
    .key_release(s_key_release),
`endif
    .clr_overflow(s_clr)
  );

  // a pressed key closes its row onto its column line
  always_comb begin
    rows = '0;
    for (int r = 0; r < ROWS; r++) rows[r] = |(press_mask[r*COLS +: COLS] & cols);
    s_rows = '0;
    for (int r = 0; r < 3; r++) s_rows[r] = |(s_press_mask[r*5 +: 5] & s_cols);
  end

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int cyc = 0;          // cycles since reset release
  int gcyc = 0;         // cycles since the first reset release
  int hist[$];          // recent frame candidates, -1 = no key
  int mdl_held = -1;
  int occ = 0;
  bit exp_ovf = 1'b0;
  bit exp_multi = 1'b0;
  int sb[$];

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          rmode;   // 0 random, 1 ready low, 2 ready high, 3 ready only in last cycle
    bit          clr;
  } seg_t;
  seg_t segs[$];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_seg(input logic [15:0] m, input int f, input int r, input bit c);
    seg_t s;
    s.mask = m; s.frames = f; s.rmode = r; s.clr = c;
    segs.push_back(s);
  endtask

  // one clock cycle: apply inputs, advance the model, then check after the edge
  task automatic step(input bit rdy, input bit clr);
    int cand;
    bit pop, push, drop, all_eq;
    key_ready    = rdy;
    clr_overflow = clr;
    pop  = (occ > 0) && rdy;
    push = 1'b0;
    drop = 1'b0;
    if ((cyc % FRAME) == FRAME - 1) begin
      cand = -1;
      for (int k = NKEY - 1; k >= 0; k--) if (press_mask[k]) cand = k;
      exp_multi = ($countones(press_mask) >= 2);
      hist.push_back(cand);
      if (hist.size() > DEB) void'(hist.pop_front());
      all_eq = (hist.size() == DEB);
      foreach (hist[i]) if (hist[i] != cand) all_eq = 1'b0;
      if (all_eq && (cand != mdl_held)) begin
        mdl_held = cand;
        if (cand >= 0) begin
          if ((occ == DEPTH) && !pop) drop = 1'b1;
          else begin
            push = 1'b1;
            sb.push_back(cand);
          end
        end
      end
    end
    occ = occ - int'(pop) + int'(push);
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
    @(posedge clk); #1;
    cyc++;
    gcyc++;
    chk("overflow", overflow, exp_ovf);
    chk("key_valid", key_valid, occ > 0);
    if ((cyc % FRAME) == 0) begin
      chk("held", held, mdl_held >= 0);
      if (mdl_held >= 0) chk("held_code", held_code, mdl_held);
      chk("multi", multi, exp_multi);
    end
    if (gcyc == 239) chk("s_valid_before_accept", s_key_valid, 0);
    if (gcyc == 240) begin
      chk("s_valid", s_key_valid, 1);
      chk("s_key_code", s_key_code, 14);
      chk("s_held_code", s_held_code, 14);
    end
  endtask

  task automatic run_seg(input seg_t s);
    bit rdy;
    for (int f = 0; f < s.frames; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        if (c == 0) press_mask = s.mask;
        case (s.rmode)
          0: rdy = 1'($urandom_range(0, 1));
          1: rdy = 1'b0;
          2: rdy = 1'b1;
          default: rdy = (f == s.frames - 1) && (c == FRAME - 1);
        endcase
        step(rdy, s.clr && (f == 0) && (c == 0));
      end
    end
  endtask

  // consumer side: every handshake pops one expected event
  always @(negedge clk) begin
    if (!reset && key_valid && key_ready) begin
      chk("event_expected", sb.size() > 0, 1);
      if (sb.size() > 0) chk("key_code", key_code, sb.pop_front());
    end
  end

  initial begin
    // directed segments
    add_seg(16'h0000, 2, 2, 1'b0);
    add_seg(16'h0040, 4, 1, 1'b0);          // key 6 held, not consumed
    add_seg(16'h0040, 3, 2, 1'b0);          // consume; still held, no repeat
    add_seg(16'h0000, 3, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin       // bounce
      add_seg(16'h0040, 1, 2, 1'b0);
      add_seg(16'h0000, 1, 2, 1'b0);
    end
    add_seg(16'h0040, 4, 2, 1'b0);
    add_seg(16'h0000, 3, 2, 1'b0);
    add_seg(16'h0208, 4, 2, 1'b0);          // keys 9 and 3
    add_seg(16'h0200, 4, 2, 1'b0);          // 3 released, 9 still held
    add_seg(16'h0000, 3, 2, 1'b0);
    for (int k = 0; k < 5; k++) add_seg(16'(1 << k), 3, 1, 1'b0);
    add_seg(16'h0000, 3, 1, 1'b1);          // clear overflow
    add_seg(16'h0000, 3, 2, 1'b0);          // drain 0..3
    for (int k = 5; k < 9; k++) add_seg(16'(1 << k), 3, 1, 1'b0);
    add_seg(16'h0400, 3, 3, 1'b0);          // full FIFO, pop in the push cycle
    add_seg(16'h0000, 3, 2, 1'b0);
    add_seg(16'h0800, 3, 1, 1'b0);
    add_seg(16'h1000, 3, 1, 1'b0);          // two entries queued

    repeat (3) @(posedge clk);
    #1;
    chk("rst_cols", cols, 1);
    chk("rst_col_idx", col_idx, 0);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_held", held, 0);
    chk("rst_held_code", held_code, 0);
    chk("rst_multi", multi, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b0;

    foreach (segs[i]) run_seg(segs[i]);

    // reset in the middle of a frame with events queued
    press_mask = '0;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
    chk("pre_rst_valid", key_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_valid", key_valid, 0);
    chk("mid_rst_cols", cols, 1);
    chk("mid_rst_col_idx", col_idx, 0);
    chk("mid_rst_held", held, 0);
    reset = 1'b0;
    cyc = 0;
    hist.delete();
    sb.delete();
    mdl_held = -1;
    occ = 0;
    exp_ovf = 1'b0;
    exp_multi = 1'b0;

    // randomized segments
    for (int n = 0; n < 30; n++) begin
      seg_t s;
      int sel;
      sel = $urandom_range(0, 3);
      s.mask = 16'h0000;
      if (sel == 1 || sel == 2) s.mask[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) begin
        s.mask[$urandom_range(0, 15)] = 1'b1;
        s.mask[$urandom_range(0, 15)] = 1'b1;
      end
      s.frames = $urandom_range(1, 4);
      s.rmode  = $urandom_range(0, 2);
      s.clr    = ($urandom_range(0, 3) == 0);
      run_seg(s);
    end

    press_mask = '0;
    for (int i = 0; i < 4 * FRAME; i++) step(1'b1, 1'b0);
    chk("all_events_seen", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
